// File: rtl/pc_ras.sv
// Program counter with a return-address stack: sequential fetch, relative and
// absolute jumps, call/return with overflow/underflow sticky error flags.
module pc_ras #(
  parameter int D     = 12,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         reljump_en,
  input  logic                         absjump_en,
  input  logic                         call_en,
  input  logic                         ret_en,
  input  logic [D-1:0]                 target,
  output logic [D-1:0]                 prog_ctr,
  output logic [D-1:0]                 ret_addr,
  output logic [$clog2(DEPTH+1)-1:0]   sp_cnt,
  output logic                         ovf_err,
  output logic                         unf_err
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);

  // Modulo-2^D increment; the carry out is intentionally dropped.
  function automatic logic [D-1:0] pc_inc(input logic [D-1:0] pc);
    pc_inc = pc + {{(D-1){1'b0}}, 1'b1};
  endfunction

  logic [D-1:0]   stack [DEPTH];
  logic [D-1:0]   pc_nx;
  logic [SPW-1:0] sp_nx;
  logic [IW-1:0]  top_idx;
  logic           push;
  logic           ovf_set;
  logic           unf_set;

  assign top_idx  = IW'(sp_cnt - SP_ONE);
  assign ret_addr = (sp_cnt == '0) ? '0 : stack[top_idx];

  // Action select: ret > call > reljump > absjump > increment
  always_comb begin
    pc_nx   = pc_inc(prog_ctr);
    sp_nx   = sp_cnt;
    push    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (ret_en) begin
      if (sp_cnt != '0) begin
        pc_nx = stack[top_idx];
        sp_nx = sp_cnt - SP_ONE;
      end else begin
        unf_set = 1'b1;
      end
    end else if (call_en) begin
      pc_nx = target;
      if (sp_cnt != SP_FULL) begin
        push  = 1'b1;
        sp_nx = sp_cnt + SP_ONE;
      end else begin
        ovf_set = 1'b1;
      end
    end else if (reljump_en) begin
      pc_nx = prog_ctr + target;
    end else if (absjump_en) begin
      pc_nx = target;
    end
  end

  // Control state: PC, stack pointer, sticky flags
  always_ff @(posedge clk) begin
    if (reset) begin
      prog_ctr <= '0;
      sp_cnt   <= '0;
      ovf_err  <= 1'b0;
      unf_err  <= 1'b0;
    end else if (!start) begin
      prog_ctr <= pc_nx;
      sp_cnt   <= sp_nx;
      ovf_err  <= ovf_err | ovf_set;
      unf_err  <= unf_err | unf_set;
    end
  end

  // Stack storage is never cleared; sp_cnt alone decides which entries are valid
  always_ff @(posedge clk) begin
    if (!reset && !start && push) begin
      stack[IW'(sp_cnt)] <= pc_inc(prog_ctr);
    end
  end

endmodule

// File: tb/tb_pc_ras.sv
// Bench for pc_ras: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a queue-based reference model.
module tb_pc_ras;
  localparam int D     = 12;
  localparam int DEPTH = 4;
  localparam int SPW   = $clog2(DEPTH + 1);

  logic           clk = 1'b0;
  logic           reset, start, reljump_en, absjump_en, call_en, ret_en;
  logic [D-1:0]   target;
  logic [D-1:0]   prog_ctr, ret_addr;
  logic [SPW-1:0] sp_cnt;
  logic           ovf_err, unf_err;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [D-1:0] m_pc;
  logic [D-1:0] m_stk[$];
  bit           m_ovf, m_unf;

  pc_ras #(.D(D), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .reljump_en(reljump_en),
    .absjump_en(absjump_en), .call_en(call_en), .ret_en(ret_en),
    .target(target), .prog_ctr(prog_ctr), .ret_addr(ret_addr),
    .sp_cnt(sp_cnt), .ovf_err(ovf_err), .unf_err(unf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Model update from the specification's per-cycle rules
  always @(posedge clk) begin
    if (reset) begin
      m_pc = '0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (!start) begin
      if (ret_en) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_pc = m_pc + 1'b1; m_unf = 1; end
      end else if (call_en) begin
        if (m_stk.size() < DEPTH) m_stk.push_back(m_pc + 1'b1);
        else m_ovf = 1;
        m_pc = target;
      end else if (reljump_en) m_pc = m_pc + target;
      else if (absjump_en) m_pc = target;
      else m_pc = m_pc + 1'b1;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("pc", int'(prog_ctr), int'(m_pc));
      chk("sp_cnt", int'(sp_cnt), m_stk.size());
      chk("ret_addr", int'(ret_addr), (m_stk.size() > 0) ? int'(m_stk[$]) : 0);
      chk("ovf_err", int'(ovf_err), int'(m_ovf));
      chk("unf_err", int'(unf_err), int'(m_unf));
    end
  end

  task automatic step(input bit r, input bit s, input bit rt, input bit cl,
                      input bit rj, input bit aj, input logic [D-1:0] tg);
    @(negedge clk);
    reset = r; start = s; ret_en = rt; call_en = cl;
    reljump_en = rj; absjump_en = aj; target = tg;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();  step(0, 0, 0, 0, 0, 0, '0); endtask
  task automatic rst();   step(1, 0, 0, 0, 0, 0, '0); endtask
  task automatic ajmp(input logic [D-1:0] t); step(0, 0, 0, 0, 0, 1, t); endtask
  task automatic call(input logic [D-1:0] t); step(0, 0, 0, 1, 0, 0, t); endtask
  task automatic ret();   step(0, 0, 1, 0, 0, 0, '0); endtask

  initial begin
    reset = 1; start = 0; ret_en = 0; call_en = 0;
    reljump_en = 0; absjump_en = 0; target = '0;
    m_pc = '0; m_ovf = 0; m_unf = 0;

    // Reset state and idle counting
    rst();
    chk_en = 1'b1;
    chk("rst_pc", int'(prog_ctr), 0);
    chk("rst_sp", int'(sp_cnt), 0);
    chk("rst_ra", int'(ret_addr), 0);
    chk("rst_flags", int'({ovf_err, unf_err}), 0);
    idle(); idle(); idle();
    chk("idle_pc3", int'(prog_ctr), 3);

    // Single call/return
    ajmp(12'h010);
    call(12'h200);
    chk("call_pc", int'(prog_ctr), 12'h200);
    chk("call_sp", int'(sp_cnt), 1);
    chk("call_ra", int'(ret_addr), 12'h011);
    ret();
    chk("ret_pc", int'(prog_ctr), 12'h011);
    chk("ret_sp", int'(sp_cnt), 0);
    chk("ret_ra", int'(ret_addr), 0);

    // Nested calls to overflow, then unwinding
    ajmp(12'h100);
    for (int i = 0; i < 5; i++) call(12'h300 + 12'(i));
    chk("ovf_sp", int'(sp_cnt), 4);
    chk("ovf_flag", int'(ovf_err), 1);
    chk("ovf_pc", int'(prog_ctr), 12'h304);
    ret(); chk("pop1", int'(prog_ctr), 12'h303);
    ret(); chk("pop2", int'(prog_ctr), 12'h302);
    ret(); chk("pop3", int'(prog_ctr), 12'h301);
    ret(); chk("pop4", int'(prog_ctr), 12'h101);
    chk("ovf_sticky", int'(ovf_err), 1);

    // Underflow, stickiness, reset clears
    rst();
    ajmp(12'h050);
    ret();
    chk("unf_pc", int'(prog_ctr), 12'h051);
    chk("unf_flag", int'(unf_err), 1);
    chk("unf_sp", int'(sp_cnt), 0);
    for (int i = 0; i < 10; i++) idle();
    chk("unf_sticky", int'(unf_err), 1);
    rst();
    chk("unf_clr", int'(unf_err), 0);

    // Wraparound, negative relative jump, hold
    ajmp(12'hFFF);
    idle();
    chk("wrap_pc", int'(prog_ctr), 0);
    ajmp(12'h005);
    step(0, 0, 0, 0, 1, 0, 12'hFFE);
    chk("rel_neg", int'(prog_ctr), 12'h003);
    call(12'h100);
    step(0, 1, 0, 1, 0, 0, 12'h007);
    chk("hold_pc", int'(prog_ctr), 12'h100);
    chk("hold_sp", int'(sp_cnt), 1);

    // Simultaneous requests and reset during call
    rst();
    ajmp(12'h03F);
    call(12'h123);
    step(0, 0, 1, 1, 0, 0, 12'h555);
    chk("cr_pc", int'(prog_ctr), 12'h040);
    chk("cr_sp", int'(sp_cnt), 0);
    chk("cr_ovf", int'(ovf_err), 0);
    step(0, 0, 0, 1, 0, 1, 12'h080);
    chk("ca_pc", int'(prog_ctr), 12'h080);
    chk("ca_sp", int'(sp_cnt), 1);
    chk("ca_ra", int'(ret_addr), 12'h041);
    step(1, 1, 0, 1, 0, 0, 12'h200);
    chk("rst_call_pc", int'(prog_ctr), 0);
    chk("rst_call_sp", int'(sp_cnt), 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 10),
           ($urandom_range(99) < 25), ($urandom_range(99) < 30),
           ($urandom_range(99) < 20), ($urandom_range(99) < 20),
           D'($urandom));
    end
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
